zion_clr_en_valid_pipe: RTL and testbench

Parametrised valid/ready pipeline register: DEPTH stages of WIDTH-bit data, each with a valid bit, bubble-collapsing backpressure, a global enable (freeze) and a synchronous clear (flush). It is the multi-stage, handshaked successor to the single clear/enable DFF. It sits between producer and consumer datapath blocks wherever registered timing slack and flushable in-flight state are both required.

---
 rtl/zion_clr_en_valid_pipe.sv | 64 ++++++
 tb/tb_zion_clr_en_valid_pipe.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/zion_clr_en_valid_pipe.sv
// zion_clr_en_valid_pipe: multi-stage valid/ready pipeline with bubble collapse, freeze and flush
module zion_clr_en_valid_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iEn,
  input  logic                       iClr,
  input  logic                       iVld,
  output logic                       oRdy,
  input  logic [WIDTH-1:0]           iDat,
  output logic                       oVld,
  input  logic                       iRdy,
  output logic [WIDTH-1:0]           oDat,
  output logic [$clog2(DEPTH+1)-1:0] oCnt
);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] vld_q, src_v;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [DEPTH:0]   adv;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc, xfer;
  // a stage advances when it is empty or the stage ahead advances
  always_comb begin
    adv[DEPTH] = iRdy;
    for (int i = DEPTH - 1; i >= 0; i--) adv[i] = iEn & ~iClr & (~vld_q[i] | adv[i+1]);
    src_v[0] = iVld;
    src_d[0] = iDat;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = vld_q[i-1];
      src_d[i] = dat_q[i-1];
    end
  end
  assign oRdy  = adv[0];
  assign oVld  = vld_q[DEPTH-1] & iEn & ~iClr;
  assign oDat  = dat_q[DEPTH-1];
  assign oCnt  = cnt_q;
  assign acc   = iVld & adv[0];
  assign xfer  = oVld & iRdy;
  assign cnt_d = cnt_q + CW'(acc) - CW'(xfer);
  always_ff @(posedge clk)
    if (rst || iClr) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= INI_DATA;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (adv[i]) begin
          vld_q[i] <= src_v[i];
          if (src_v[i]) dat_q[i] <= src_d[i];
        end
      cnt_q <= cnt_d;
    end
  if (DEPTH < 1 || WIDTH < 1) begin : g_bad_param
`ifdef CHECK_ERR_EXIT
    $fatal(1, "zion_clr_en_valid_pipe: DEPTH and WIDTH must be >= 1");
`else
    $error("zion_clr_en_valid_pipe: DEPTH and WIDTH must be >= 1");
`endif
  end
endmodule

// File: tb/tb_zion_clr_en_valid_pipe.sv
// tb_zion_clr_en_valid_pipe: random and directed scoreboard bench for DEPTH=3 and DEPTH=1 pipes
module tb_zion_clr_en_valid_pipe;
  localparam logic [7:0] INI = 8'hA5;
  logic clk = 0, rst = 1, en = 1, clr = 0, vin = 0, rdy = 0;
  logic [7:0] din = 0;
  logic r3, v3, r1, v1;
  logic [7:0] d3, d1;
  logic [1:0] c3;
  logic [0:0] c1;
  int tests = 0, fails = 0;
  int pos [2][4];
  logic [7:0] dq [2][4];
  int n [2];
  logic [7:0] lastd [2];
  logic [7:0] eq0 [$];
  logic [7:0] eq1 [$];
  always #5 clk = ~clk;
  zion_clr_en_valid_pipe #(.WIDTH(8), .DEPTH(3), .INI_DATA(INI)) u3 (
    .clk(clk), .rst(rst), .iEn(en), .iClr(clr), .iVld(vin), .oRdy(r3), .iDat(din),
    .oVld(v3), .iRdy(rdy), .oDat(d3), .oCnt(c3));
  zion_clr_en_valid_pipe #(.WIDTH(8), .DEPTH(1), .INI_DATA(INI)) u1 (
    .clk(clk), .rst(rst), .iEn(en), .iClr(clr), .iVld(vin), .oRdy(r1), .iDat(din),
    .oVld(v1), .iRdy(rdy), .oDat(d1), .oCnt(c1));
  task automatic chk(string nm, int id, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, id, $time, a, e);
    end
  endtask
  task automatic flush(int id);
    n[id] = 0;
    lastd[id] = INI;
    if (id == 0) eq0.delete(); else eq1.delete();
  endtask
  // reference: items tracked by stage position; each slides forward while a slot ahead frees up
  task automatic step(int id, int dep, logic ro, logic vo, logic [7:0] dout, int co);
    logic er, ev;
    int b, m, p;
    int np [4];
    logic [7:0] nd [4];
    if (rst) begin flush(id); return; end
    er = en && !clr && (n[id] < dep || rdy);
    ev = en && !clr && n[id] > 0 && pos[id][0] == dep - 1;
    chk("oRdy", id, int'(ro), int'(er));
    chk("oVld", id, int'(vo), int'(ev));
    chk("oCnt", id, co, n[id]);
    chk("oDat", id, int'(dout), int'(lastd[id]));
    if (clr) begin flush(id); return; end
    if (!en) return;
    b = dep;
    m = 0;
    for (int i = 0; i < n[id]; i++) begin
      if (pos[id][i] == dep - 1 && rdy) continue;
      p = (pos[id][i] + 1 < b) ? pos[id][i] + 1 : pos[id][i];
      if (p == dep - 1 && pos[id][i] != dep - 1) lastd[id] = dq[id][i];
      np[m] = p;
      nd[m] = dq[id][i];
      m++;
      b = p;
    end
    if (vin && er) begin
      np[m] = 0;
      nd[m] = din;
      m++;
      if (dep == 1) lastd[id] = din;
      if (id == 0) eq0.push_back(din); else eq1.push_back(din);
    end
    for (int i = 0; i < m; i++) begin
      pos[id][i] = np[i];
      dq[id][i] = nd[i];
    end
    n[id] = m;
  endtask
  always @(negedge clk) begin
    step(0, 3, r3, v3, d3, int'(c3));
    step(1, 1, r1, v1, d1, int'(c1));
  end
  always @(negedge clk)
    if (!rst && v3 && rdy) begin
      tests++;
      if (eq0.size() == 0) begin
        fails++;
        $display("FAIL mon dut0 @%0t: got output %0h expected none", $time, d3);
      end else begin
        logic [7:0] e;
        e = eq0.pop_front();
        if (d3 !== e) begin
          fails++;
          $display("FAIL mon dut0 @%0t: got %0h expected %0h", $time, d3, e);
        end
      end
    end
  always @(negedge clk)
    if (!rst && v1 && rdy) begin
      tests++;
      if (eq1.size() == 0) begin
        fails++;
        $display("FAIL mon dut1 @%0t: got output %0h expected none", $time, d1);
      end else begin
        logic [7:0] e;
        e = eq1.pop_front();
        if (d1 !== e) begin
          fails++;
          $display("FAIL mon dut1 @%0t: got %0h expected %0h", $time, d1, e);
        end
      end
    end
  task automatic drive(logic rs, logic v, logic [7:0] d, logic r, logic e, logic c);
    @(posedge clk);
    #1;
    rst = rs; vin = v; din = d; rdy = r; en = e; clr = c;
  endtask
  initial begin
    drive(1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) drive(0, 1, 8'(i), 1, 1, 0);
    repeat (4) drive(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'h10 + 8'(i), 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 8'h13, 1, 1, 0);
    repeat (4) drive(0, 0, 0, 1, 1, 0);
    drive(0, 1, 8'h20, 0, 1, 0);
    drive(0, 1, 8'h21, 0, 1, 0);
    drive(0, 1, 8'h22, 1, 1, 1);
    repeat (3) drive(0, 0, 0, 1, 1, 0);
    drive(0, 1, 8'h30, 0, 1, 0);
    drive(0, 1, 8'h31, 0, 1, 0);
    repeat (4) drive(0, 1, 8'h3F, 1, 0, 0);
    repeat (5) drive(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 299) == 0, 1'($urandom), 8'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
    repeat (8) drive(0, 0, 0, 1, 1, 0);
    @(negedge clk);
    #1;
    chk("drain", 0, eq0.size(), 0);
    chk("drain", 1, eq1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
